add_subtract_serial: RTL and testbench

Bit-serial, multi-cycle signed/unsigned add/subtract unit. It consumes the same operand interface as the combinational structural adder: a, b and dir (0 = add, 1 = subtract). It produces the same result set (rslt, per-bit ripple carries, final carry, ovfl) over WIDTH clock cycles under a start/busy/done handshake. It is intended for area-constrained datapaths where one full-adder cell is time-shared across all bit positions.

---
 rtl/add_subtract_serial_if.sv | 26 ++
 rtl/add_subtract_serial.sv | 112 +++++++++++
 tb/tb_add_subtract_serial.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/add_subtract_serial_if.sv
// Operand/result bundle for the bit-serial add/subtract unit.
// The master drives the request side; the slave returns status and results.
interface add_subtract_serial_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             dir;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rslt;
    logic [WIDTH-2:0] cout;
    logic             cout_msb;
    logic             ovfl;

    modport master (
        output start, a, b, dir,
        input  busy, done, rslt, cout, cout_msb, ovfl
    );

    modport slave (
        input  start, a, b, dir,
        output busy, done, rslt, cout, cout_msb, ovfl
    );
endinterface

// File: rtl/add_subtract_serial.sv
// Bit-serial add/subtract: one time-shared full-adder cell walks the operands
// LSB first over WIDTH cycles and publishes sum, per-bit carries and overflow on done.
module add_subtract_serial #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_subtract_serial_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] carry_sr;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rslt;
    logic [WIDTH-2:0] cout;
    logic             cout_msb;
    logic             ovfl;

    logic [1:0]       fa;
    logic [WIDTH-1:0] sum_nx;
    logic [WIDTH-1:0] carry_nx;
    logic             last_bit;

    // Returns {carry_out, sum} of a single full-adder cell.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    always_comb begin
        fa            = full_add(op_a[cnt], op_b[cnt], carry);
        sum_nx        = sum_sr;
        sum_nx[cnt]   = fa[0];
        carry_nx      = carry_sr;
        carry_nx[cnt] = fa[1];
        last_bit      = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_sr   <= '0;
            carry_sr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rslt     <= '0;
            cout     <= '0;
            cout_msb <= 1'b0;
            ovfl     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract is a + ~b + 1: invert b now, seed the carry with dir.
                        op_a  <= bus.a;
                        op_b  <= bus.b ^ {WIDTH{bus.dir}};
                        carry <= bus.dir;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sr   <= sum_nx;
                    carry_sr <= carry_nx;
                    carry    <= fa[1];
                    cnt      <= cnt + 1'b1;
                    if (last_bit) begin
                        rslt     <= sum_nx;
                        cout     <= carry_nx[WIDTH-2:0];
                        cout_msb <= fa[1];
                        ovfl     <= carry_nx[WIDTH-2] ^ fa[1];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rslt     = rslt;
    assign bus.cout     = cout;
    assign bus.cout_msb = cout_msb;
    assign bus.ovfl     = ovfl;
endmodule

// File: tb/tb_add_subtract_serial.sv
// Bench for add_subtract_serial: directed table, handshake and reset corner
// cases, exhaustive sweep and random operations against an arithmetic model.
module tb_add_subtract_serial;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] rslt;
        logic [W-2:0] cout;
        logic         msb;
        logic         ovfl;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         dir;
        res_t         exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    add_subtract_serial_if #(.WIDTH(W)) bus ();

    add_subtract_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic; carry out of bit i is bit i+1 of the partial sum.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic dir);
        res_t        r;
        logic [31:0] bv;
        logic [31:0] full;
        logic [31:0] mask;
        logic [31:0] part;
        bv     = dir ? (~b & ((32'd1 << W) - 1)) : (b & ((32'd1 << W) - 1));
        full   = (a & ((32'd1 << W) - 1)) + bv + {31'd0, dir};
        r.rslt = full[W-1:0];
        r.msb  = full[W];
        for (int i = 0; i < W - 1; i++) begin
            mask      = (32'd1 << (i + 1)) - 1;
            part      = ((a & mask) + (bv & mask) + {31'd0, dir}) >> (i + 1);
            r.cout[i] = part[0];
        end
        r.ovfl = r.cout[W-2] ^ r.msb;
        return r;
    endfunction

    task automatic check_res(input string tag, input res_t e);
        check({tag, "_rslt"}, 32'(bus.rslt), 32'(e.rslt));
        check({tag, "_cout"}, 32'(bus.cout), 32'(e.cout));
        check({tag, "_msb"},  32'(bus.cout_msb), 32'(e.msb));
        check({tag, "_ovfl"}, 32'(bus.ovfl), 32'(e.ovfl));
    endtask

    // Issue one operation, watch busy/done and compare the result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic dir, input res_t e, input bit jitter);
        int           busy_n;
        bit           got;
        bit           stable;
        logic [W-1:0] hold_r;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.dir   = dir;
        @(negedge clk);
        bus.start = 1'b0;
        hold_r    = bus.rslt;
        busy_n    = 0;
        got       = 1'b0;
        stable    = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_n++;
                if (bus.rslt !== hold_r) stable = 1'b0;
                if (jitter) begin
                    bus.a   = W'($urandom);
                    bus.b   = W'($urandom);
                    bus.dir = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
        check({tag, "_hold"}, 32'(stable), 32'd1);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check_res(tag, e);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    vec_t vecs[5];
    res_t e;
    int   done_n;
    int   last_t;
    int   gaps_bad;
    int   pulses;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{a: 4'b0010, b: 4'b0001, dir: 1'b0, exp: '{rslt: 4'b0011, cout: 3'b000, msb: 1'b0, ovfl: 1'b0}};
        vecs[1] = '{a: 4'b1110, b: 4'b0111, dir: 1'b0, exp: '{rslt: 4'b0101, cout: 3'b110, msb: 1'b1, ovfl: 1'b0}};
        vecs[2] = '{a: 4'b1111, b: 4'b1111, dir: 1'b1, exp: '{rslt: 4'b0000, cout: 3'b111, msb: 1'b1, ovfl: 1'b0}};
        vecs[3] = '{a: 4'b0100, b: 4'b1000, dir: 1'b1, exp: '{rslt: 4'b1100, cout: 3'b111, msb: 1'b0, ovfl: 1'b1}};
        vecs[4] = '{a: 4'b0010, b: 4'b0001, dir: 1'b1, exp: '{rslt: 4'b0001, cout: 3'b110, msb: 1'b1, ovfl: 1'b0}};

        // Reset and idle
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.dir   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_res("rst", '0);
        rst_n  = 1'b1;
        done_n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_n++;
        end
        check("idle_quiet", 32'(done_n), 32'd0);

        // Directed table
        for (int i = 0; i < 4; i++) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].dir, vecs[i].exp, 1'b0);

        // Start during busy is ignored
        e = model(32'd3, 32'd5, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd3; bus.b = 4'd5; bus.dir = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd2; bus.dir = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        done_n = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.done) begin
                done_n++;
                check_res("ignore", e);
            end
            @(negedge clk);
        end
        check("ignore_done_count", 32'(done_n), 32'd1);

        // Start held high: one done every WIDTH+2 cycles
        e = model(32'd6, 32'd7, 1'b0);
        bus.start = 1'b1; bus.a = 4'd6; bus.b = 4'd7; bus.dir = 1'b0;
        pulses = 0; last_t = -1; gaps_bad = 0;
        for (int t = 0; t < 26; t++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last_t >= 0 && (t - last_t) != W + 2) gaps_bad++;
                last_t = t;
                pulses++;
            end
        end
        bus.start = 1'b0;
        check("b2b_pulses", 32'(pulses >= 4), 32'd1);
        check("b2b_gaps", 32'(gaps_bad), 32'd0);
        check_res("b2b", e);
        repeat (8) @(negedge clk);

        // Reset in the second SHIFT cycle
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd6; bus.dir = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check_res("midrst", '0);
        done_n = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_n++;
        end
        check("midrst_no_done", 32'(done_n), 32'd0);
        run_op("post_rst", vecs[4].a, vecs[4].b, vecs[4].dir, vecs[4].exp, 1'b0);

        // Exhaustive sweep
        for (int d = 0; d < 2; d++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run_op($sformatf("sw_%0d_%0d_%0d", x, y, d), W'(x), W'(y), 1'(d),
                           model(32'(x), 32'(y), 1'(d)), 1'b0);

        // Random operations with operand changes while busy
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rd;
            ra = W'($urandom);
            rb = W'($urandom);
            rd = 1'($urandom);
            run_op($sformatf("rnd%0d", n), ra, rb, rd, model(32'(ra), 32'(rb), rd), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
